// File: rtl/vfpm_pkg.sv
// Shared types for the vector FP multiply sequencer: element width, FSM states
// and the in-flight element tag carried alongside the multiplier pipeline.
package vfpm_pkg;
    localparam int FP_W      = 32;
    localparam int IDX_MAX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/vfpm_tag_pipe.sv
// LAT-deep tag shift register that mirrors the multiplier latency, so a tag
// pushed with an issue emerges exactly when that element's product returns.
module vfpm_tag_pipe
    import vfpm_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[LAT-1];

endmodule

// File: rtl/vfpm_sequencer.sv
// Drives one vector multiply through the shared scalar FP multiplier and
// gathers the returning products into a result vector behind a valid/ack.
//
//   state | meaning
//   IDLE  | waiting for start; counters cleared
//   ISSUE | one element pair on mul_a/mul_b per cycle, VLEN cycles
//   DRAIN | issue finished, waiting for the last product to return
//   DONE  | result_vec/ov_mask held with result_valid until result_ack
module vfpm_sequencer
    import vfpm_pkg::*;
#(
    parameter int VLEN = 4,
    parameter int LAT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VLEN*FP_W-1:0] vec_a,
    input  logic [VLEN*FP_W-1:0] vec_b,
    output logic                 busy,
    output logic [FP_W-1:0]      mul_a,
    output logic [FP_W-1:0]      mul_b,
    output logic                 mul_valid,
    input  logic [FP_W-1:0]      mul_res,
    input  logic                 mul_ov,
    output logic [VLEN*FP_W-1:0] result_vec,
    output logic [VLEN-1:0]      ov_mask,
    output logic                 result_valid,
    input  logic                 result_ack
);

    localparam int CNT_W = $clog2(VLEN + 1);

    state_t                r_state;
    logic [VLEN*FP_W-1:0]  r_a;
    logic [VLEN*FP_W-1:0]  r_b;
    logic [CNT_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cap;
    logic [FP_W-1:0]       r_mul_a;
    logic [FP_W-1:0]       r_mul_b;
    logic                  r_mul_valid;
    logic                  r_busy;
    logic [VLEN*FP_W-1:0]  r_result;
    logic [VLEN-1:0]       r_ov;
    logic                  r_result_valid;

    tag_t                  w_tag_in;
    tag_t                  w_tag_out;
    logic [CNT_W-1:0]      w_idx_next;
    logic [CNT_W-1:0]      w_cap_next;

    // r_idx names the element currently on mul_a/mul_b, so the tag pushed this
    // cycle describes exactly what the multiplier samples at the next edge.
    assign w_tag_in   = {r_mul_valid, IDX_MAX_W'(r_idx)};
    assign w_idx_next = r_idx + 1'b1;
    assign w_cap_next = r_cap + CNT_W'(w_tag_out.valid);

    vfpm_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_idx          <= '0;
            r_cap          <= '0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_mul_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_ov           <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_tag_out.valid) begin
                r_cap <= w_cap_next;
                for (int i = 0; i < VLEN; i++) begin
                    if (w_tag_out.idx == IDX_MAX_W'(i)) begin
                        r_result[i*FP_W +: FP_W] <= mul_res;
                        r_ov[i]                  <= mul_ov;
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a         <= vec_a;
                        r_b         <= vec_b;
                        r_mul_a     <= vec_a[FP_W-1:0];
                        r_mul_b     <= vec_b[FP_W-1:0];
                        r_mul_valid <= 1'b1;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_idx == CNT_W'(VLEN - 1)) begin
                        r_mul_valid <= 1'b0;
                        r_state     <= DRAIN;
                    end else begin
                        r_idx <= w_idx_next;
                        for (int i = 0; i < VLEN; i++) begin
                            if (w_idx_next == CNT_W'(i)) begin
                                r_mul_a <= r_a[i*FP_W +: FP_W];
                                r_mul_b <= r_b[i*FP_W +: FP_W];
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_cap_next == CNT_W'(VLEN)) begin
                        r_result_valid <= 1'b1;
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_idx          <= '0;
                        r_cap          <= '0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign mul_valid    = r_mul_valid;
    assign result_vec   = r_result;
    assign ov_mask      = r_ov;
    assign result_valid = r_result_valid;

endmodule
